// File: rtl/multiexp_stream_ctl.sv
// Replays NUM_IN RAM pairs to a multiexp core for KEY_BITS passes (or one pair), then returns the core result.
// First beat 2 clks after start, then 1 beat/clk; a 1-entry skid keeps RAM reads off i_ps_rdy; result held until i_pnt_rdy.
module multiexp_stream_ctl #(
  parameter int PNT_BITS = 512,
  parameter int SCL_BITS = 256,
  parameter int RES_BITS = 768,
  parameter int NUM_IN   = 8,
  parameter int KEY_BITS = 256,
  parameter int CTL_BITS = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_wr_val,
  input  logic [$clog2(NUM_IN)-1:0]       i_wr_addr,
  input  logic [PNT_BITS+SCL_BITS-1:0]    i_wr_dat,
  output logic                            o_wr_rdy,
  input  logic                            i_start,
  input  logic                            i_mode,
  output logic                            o_ps_val,
  output logic [PNT_BITS+SCL_BITS-1:0]    o_ps_dat,
  output logic [CTL_BITS-1:0]             o_ps_ctl,
  output logic                            o_ps_sop,
  output logic                            o_ps_eop,
  input  logic                            i_ps_rdy,
  input  logic                            i_res_val,
  input  logic [RES_BITS-1:0]             i_res_dat,
  output logic                            o_res_rdy,
  output logic                            o_pnt_val,
  output logic [RES_BITS-1:0]             o_pnt_dat,
  input  logic                            i_pnt_rdy,
  output logic                            o_busy,
  output logic                            o_err,
  output logic [$clog2(KEY_BITS+1)-1:0]   o_pass_cnt
);
  localparam int DW = PNT_BITS + SCL_BITS;
  localparam int IW = $clog2(NUM_IN);
  localparam int PW = $clog2(KEY_BITS + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_IN - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(KEY_BITS - 1);
  localparam logic [PW-1:0] MAX_PASS  = PW'(KEY_BITS);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, OUTPUT} state_t;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          sop;
    logic          eop;
    logic          last;
  } beat_t;

  state_t state_q, state_d;

  logic [DW-1:0]       mem [NUM_IN];
  logic                mode_q;
  logic [IW-1:0]       rd_idx_q;
  logic [PW-1:0]       iss_pass_q;
  logic                iss_done_q;
  logic                out_vld_q;
  beat_t               out_q;
  logic                skd_vld_q;
  beat_t               skd_q;
  logic [PW-1:0]       pass_q;
  logic                err_q;
  logic [RES_BITS-1:0] res_q;

  logic  start_ok, wr_ok, rd_en, ps_acc, res_acc, err_set;
  beat_t rd_beat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    o_wr_rdy  = 1'b0;
    o_busy    = 1'b1;
    o_res_rdy = 1'b0;
    o_pnt_val = 1'b0;
    start_ok  = 1'b0;
    rd_en     = 1'b0;
    res_acc   = 1'b0;
    ps_acc    = out_vld_q && i_ps_rdy;
    case (state_q)
      IDLE: begin
        o_wr_rdy = 1'b1;
        o_busy   = 1'b0;
        start_ok = i_start;
        if (i_start) state_d = STREAM;
      end
      STREAM: begin
        // Result port stays open here so a premature core result aborts the run.
        o_res_rdy = 1'b1;
        rd_en     = !iss_done_q && !skd_vld_q;
        res_acc   = i_res_val;
        if (i_res_val)                 state_d = OUTPUT;
        else if (ps_acc && out_q.last) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        o_res_rdy = 1'b1;
        res_acc   = i_res_val;
        if (i_res_val) state_d = OUTPUT;
      end
      OUTPUT: begin
        o_pnt_val = 1'b1;
        if (i_pnt_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_ok   = i_wr_val && o_wr_rdy && (i_wr_addr <= LAST_IDX);
  assign err_set = (i_start && o_busy) ||
                   (i_res_val && (state_q == IDLE || state_q == STREAM));

  always_comb begin
    rd_beat.dat  = mem[rd_idx_q];
    rd_beat.sop  = (rd_idx_q == '0);
    rd_beat.eop  = mode_q || (rd_idx_q == LAST_IDX);
    rd_beat.last = mode_q || ((rd_idx_q == LAST_IDX) && (iss_pass_q == LAST_PASS));
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[i_wr_addr] <= i_wr_dat;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q     <= 1'b0;
      rd_idx_q   <= '0;
      iss_pass_q <= '0;
      iss_done_q <= 1'b0;
      pass_q     <= '0;
      err_q      <= 1'b0;
      res_q      <= '0;
    end else begin
      if (start_ok) begin
        mode_q     <= i_mode;
        rd_idx_q   <= '0;
        iss_pass_q <= '0;
        iss_done_q <= 1'b0;
        pass_q     <= '0;
      end else begin
        if (rd_en) begin
          rd_idx_q <= (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + 1'b1;
          if (rd_idx_q == LAST_IDX) iss_pass_q <= iss_pass_q + 1'b1;
          if (rd_beat.last)         iss_done_q <= 1'b1;
        end
        if (ps_acc && out_q.eop && pass_q != MAX_PASS) pass_q <= pass_q + 1'b1;
      end
      if (start_ok)     err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
      if (res_acc) res_q <= i_res_dat;
    end
  end

  // Output register plus skid: a beat read while the output stalls parks in the skid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
      skd_vld_q <= 1'b0;
      skd_q     <= '0;
    end else if (state_q != STREAM || res_acc) begin
      out_vld_q <= 1'b0;
      skd_vld_q <= 1'b0;
    end else if (!out_vld_q || i_ps_rdy) begin
      if (skd_vld_q) begin
        out_q     <= skd_q;
        skd_vld_q <= 1'b0;
      end else if (rd_en) begin
        out_q     <= rd_beat;
        out_vld_q <= 1'b1;
      end else begin
        out_vld_q <= 1'b0;
      end
    end else if (rd_en) begin
      skd_q     <= rd_beat;
      skd_vld_q <= 1'b1;
    end
  end

  assign o_ps_val   = out_vld_q;
  assign o_ps_dat   = out_q.dat;
  assign o_ps_sop   = out_q.sop;
  assign o_ps_eop   = out_q.eop;
  assign o_ps_ctl   = CTL_BITS'(mode_q);
  assign o_pnt_dat  = res_q;
  assign o_err      = err_q;
  assign o_pass_cnt = pass_q;

endmodule

// File: tb/tb_multiexp_stream_ctl.sv
// Scoreboard bench: stimulus queues expected beats/results, a negedge monitor pops and compares on each handshake.
module tb_multiexp_stream_ctl;
  localparam int PNT_BITS = 512;
  localparam int SCL_BITS = 256;
  localparam int RES_BITS = 768;
  localparam int NUM_IN   = 4;
  localparam int KEY_BITS = 3;
  localparam int CTL_BITS = 8;
  localparam int DW       = PNT_BITS + SCL_BITS;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic [7:0]    ctl;
    logic          sop;
    logic          eop;
  } beat_t;

  typedef struct packed {
    logic [RES_BITS-1:0] dat;
    logic                err;
  } res_t;

  logic                i_clk = 1'b0;
  logic                i_rst_n = 1'b0;
  logic                i_wr_val = 1'b0;
  logic [1:0]          i_wr_addr = '0;
  logic [DW-1:0]       i_wr_dat = '0;
  logic                o_wr_rdy;
  logic                i_start = 1'b0;
  logic                i_mode = 1'b0;
  logic                o_ps_val;
  logic [DW-1:0]       o_ps_dat;
  logic [7:0]          o_ps_ctl;
  logic                o_ps_sop;
  logic                o_ps_eop;
  logic                i_ps_rdy = 1'b1;
  logic                i_res_val = 1'b0;
  logic [RES_BITS-1:0] i_res_dat = '0;
  logic                o_res_rdy;
  logic                o_pnt_val;
  logic [RES_BITS-1:0] o_pnt_dat;
  logic                i_pnt_rdy = 1'b1;
  logic                o_busy;
  logic                o_err;
  logic [1:0]          o_pass_cnt;

  multiexp_stream_ctl #(
    .PNT_BITS(PNT_BITS), .SCL_BITS(SCL_BITS), .RES_BITS(RES_BITS),
    .NUM_IN(NUM_IN), .KEY_BITS(KEY_BITS), .CTL_BITS(CTL_BITS)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_wr_val(i_wr_val), .i_wr_addr(i_wr_addr), .i_wr_dat(i_wr_dat), .o_wr_rdy(o_wr_rdy),
    .i_start(i_start), .i_mode(i_mode),
    .o_ps_val(o_ps_val), .o_ps_dat(o_ps_dat), .o_ps_ctl(o_ps_ctl),
    .o_ps_sop(o_ps_sop), .o_ps_eop(o_ps_eop), .i_ps_rdy(i_ps_rdy),
    .i_res_val(i_res_val), .i_res_dat(i_res_dat), .o_res_rdy(o_res_rdy),
    .o_pnt_val(o_pnt_val), .o_pnt_dat(o_pnt_dat), .i_pnt_rdy(i_pnt_rdy),
    .o_busy(o_busy), .o_err(o_err), .o_pass_cnt(o_pass_cnt)
  );

  always #5 i_clk = ~i_clk;

  beat_t         exp_q[$];
  res_t          rexp_q[$];
  logic [DW-1:0] pairs [NUM_IN];
  int            n_vec = 0;
  int            n_bad = 0;
  int            beats_seen = 0;
  bit            rdy_toggle = 1'b0;

  task automatic chk(input string nm, input logic [799:0] act, input logic [799:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Core-side ready: steady high, or alternating when rdy_toggle is set.
  initial forever begin
    @(posedge i_clk);
    #1;
    if (rdy_toggle) i_ps_rdy = ~i_ps_rdy;
    else            i_ps_rdy = 1'b1;
  end

  beat_t prev_beat;
  bit    prev_stall = 1'b0;

  always @(negedge i_clk) begin
    beat_t cur;
    beat_t eb;
    res_t  er;
    cur = '{o_ps_dat, o_ps_ctl, o_ps_sop, o_ps_eop};
    if (!i_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_val", 800'(o_ps_val), 800'(1));
        chk("hold_beat", 800'(cur), 800'(prev_beat));
      end
      if (o_ps_val && i_ps_rdy) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL extra_beat: got unexpected beat dat %0h", o_ps_dat);
        end else begin
          eb = exp_q.pop_front();
          chk("beat", 800'(cur), 800'(eb));
        end
      end
      prev_stall = o_ps_val && !i_ps_rdy;
      prev_beat  = cur;
      if (o_pnt_val && i_pnt_rdy) begin
        if (rexp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL extra_result: got unexpected result %0h", o_pnt_dat);
        end else begin
          er = rexp_q.pop_front();
          chk("result", 800'({o_pnt_dat, o_err}), 800'(er));
        end
      end
    end
  end

  task automatic push_normal();
    for (int p = 0; p < KEY_BITS; p++)
      for (int i = 0; i < NUM_IN; i++)
        exp_q.push_back('{pairs[i], 8'h00, (i == 0), (i == NUM_IN - 1)});
  endtask

  task automatic start_run(input logic mode);
    if (mode) exp_q.push_back('{pairs[0], 8'h01, 1'b1, 1'b1});
    else      push_normal();
    i_mode  = mode;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (beats_seen < target && n < 200) begin tick(); n++; end
    if (beats_seen < target) begin
      n_vec++; n_bad++;
      $display("FAIL beat_count_timeout: got %0d beats expected %0d", beats_seen, target);
    end
  endtask

  task automatic finish_stream(input logic [1:0] exp_pass);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    if (exp_q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL stream_timeout: got %0d beats outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge i_clk);
    chk("val_drop", 800'(o_ps_val), 800'(0));
    chk("pass_cnt", 800'(o_pass_cnt), 800'(exp_pass));
    chk("wait_res_rdy", 800'(o_res_rdy), 800'(1));
  endtask

  task automatic give_result(input logic [RES_BITS-1:0] r, input logic e_err);
    int n = 0;
    rexp_q.push_back('{r, e_err});
    i_res_val = 1'b1;
    i_res_dat = r;
    tick();
    i_res_val = 1'b0;
    while (rexp_q.size() != 0 && n < 50) begin tick(); n++; end
    if (rexp_q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL result_timeout: got no result expected %0h", r);
      rexp_q.delete();
    end
    @(negedge i_clk);
    chk("idle_busy", 800'(o_busy), 800'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge i_clk);
    chk("rst_wr_rdy", 800'(o_wr_rdy), 800'(1));
    chk("rst_outs", 800'({o_ps_val, o_busy, o_err, o_pnt_val, o_res_rdy, o_pass_cnt}), 800'(0));
    tick();
    i_rst_n = 1'b1;
    tick();

    for (int i = 0; i < NUM_IN; i++) begin
      pairs[i]  = {PNT_BITS'(64'hB0B0_0000_0000_0000 + 64'(i)), SCL_BITS'(i + 1)};
      i_wr_val  = 1'b1;
      i_wr_addr = 2'(i);
      i_wr_dat  = pairs[i];
      tick();
    end
    i_wr_val = 1'b0;

    // Normal run with continuous ready, including first-beat latency.
    start_run(1'b0);
    @(negedge i_clk);
    chk("lat_c1", 800'(o_ps_val), 800'(0));
    tick();
    @(negedge i_clk);
    chk("lat_c2", 800'(o_ps_val), 800'(1));
    finish_stream(2'd3);
    give_result(768'h1111, 1'b0);

    // Same run with ready alternating every cycle.
    rdy_toggle = 1'b1;
    start_run(1'b0);
    finish_stream(2'd3);
    rdy_toggle = 1'b0;
    give_result(768'h2222, 1'b0);

    // Single-add mode.
    start_run(1'b1);
    finish_stream(2'd1);
    give_result(768'hABC, 1'b0);

    // Result arriving while idle is dropped and flagged.
    i_res_val = 1'b1;
    i_res_dat = 768'hDEAD;
    tick();
    i_res_val = 1'b0;
    @(negedge i_clk);
    chk("idle_res_err", 800'(o_err), 800'(1));
    chk("idle_res_drop", 800'(o_pnt_val), 800'(0));

    // Early result after 5 beats aborts the stream.
    beats_seen = 0;
    start_run(1'b0);
    @(negedge i_clk);
    chk("start_clr_err", 800'(o_err), 800'(0));
    wait_beats(5);
    rexp_q.push_back('{768'h3333, 1'b1});
    i_res_val = 1'b1;
    i_res_dat = 768'h3333;
    tick();
    i_res_val = 1'b0;
    exp_q.delete();
    @(negedge i_clk);
    chk("early_stop", 800'(o_ps_val), 800'(0));
    chk("early_out", 800'({o_pnt_val, o_err}), 800'(2'b11));
    tick();
    @(negedge i_clk);
    chk("early_idle", 800'(o_busy), 800'(0));

    // Next start clears the sticky error.
    start_run(1'b1);
    @(negedge i_clk);
    chk("restart_clr_err", 800'(o_err), 800'(0));
    finish_stream(2'd1);
    give_result(768'h4444, 1'b0);

    // Start and write during the stream are ignored; error set.
    beats_seen = 0;
    start_run(1'b0);
    wait_beats(3);
    i_start   = 1'b1;
    i_mode    = 1'b1;
    i_wr_val  = 1'b1;
    i_wr_addr = 2'd1;
    i_wr_dat  = '1;
    tick();
    i_start  = 1'b0;
    i_wr_val = 1'b0;
    @(negedge i_clk);
    chk("busy_start_err", 800'(o_err), 800'(1));
    finish_stream(2'd3);
    give_result(768'h5555, 1'b1);

    // RAM unchanged by the ignored write.
    start_run(1'b0);
    finish_stream(2'd3);
    give_result(768'h6666, 1'b0);

    // Reset in the middle of the stream.
    beats_seen = 0;
    start_run(1'b0);
    wait_beats(6);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("mid_rst_val", 800'(o_ps_val), 800'(0));
    chk("mid_rst_busy", 800'(o_busy), 800'(0));
    chk("mid_rst_wr_rdy", 800'(o_wr_rdy), 800'(1));
    exp_q.delete();
    tick();
    i_rst_n = 1'b1;
    tick();
    start_run(1'b0);
    finish_stream(2'd3);
    give_result(768'h7777, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multiexp_stream_ctl.md
Name: multiexp_stream_ctl

Overview:
- Sequencer that feeds one multiexp core.
- Holds NUM_IN point/scalar pairs in local RAM, loaded over a write port.
- On start, replays the pairs as a looping stream for exactly KEY_BITS passes (normal mode) or sends one pair (single-add mode).
- Captures the core's single result point and presents it on a result output with a done handshake and an error flag.

Parameters:
- PNT_BITS, 512: width of one affine input point (x,y).
- SCL_BITS, 256: width of one scalar; KEY_BITS must not exceed it.
- RES_BITS, 768: width of the result point from the core (x,y,z).
- NUM_IN, 8: number of pairs in RAM; must be at least 2.
- KEY_BITS, 256: number of passes over the RAM in normal mode.
- CTL_BITS, 8: width of the ctl field on the stream to the core.

Ports:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_wr_val, in, 1: RAM write strobe.
- i_wr_addr, in, $clog2(NUM_IN): RAM write address.
- i_wr_dat, in, PNT_BITS+SCL_BITS: write data {point, scalar}, scalar in the LSBs.
- o_wr_rdy, out, 1: high only in IDLE; a write occurs on val&&rdy.
- i_start, in, 1: single-cycle start pulse.
- i_mode, in, 1: sampled with i_start; 0 = normal, 1 = single-add.
- o_ps_val, out, 1: pair stream valid, to the core.
- o_ps_dat, out, PNT_BITS+SCL_BITS: pair data {point, scalar}.
- o_ps_ctl, out, CTL_BITS: ctl[0] = mode; other bits 0.
- o_ps_sop, out, 1: high on the beat for index 0.
- o_ps_eop, out, 1: high on the beat for index NUM_IN-1; in single-add mode also high on the single beat.
- i_ps_rdy, in, 1: core ready for the pair stream.
- i_res_val, in, 1: core result valid.
- i_res_dat, in, RES_BITS: core result point.
- o_res_rdy, out, 1: result accept to the core.
- o_pnt_val, out, 1: final result valid, downstream.
- o_pnt_dat, out, RES_BITS: final result point.
- i_pnt_rdy, in, 1: downstream ready for the result.
- o_busy, out, 1: high in every state except IDLE.
- o_err, out, 1: sticky protocol error flag.
- o_pass_cnt, out, $clog2(KEY_BITS+1): number of completed passes.

Behaviour:
- Reset (async, i_rst_n=0) drives: state IDLE; all outputs 0 except o_wr_rdy=1; index counter 0; pass counter 0; o_err 0.
  - Reset mid-operation abandons the run. RAM contents are not cleared.
- States:
  - IDLE -> STREAM: on i_start. Latch mode, clear pass_cnt, clear index, clear o_err.
  - STREAM -> WAIT_RES: after the last required beat is accepted.
  - WAIT_RES -> OUTPUT: on i_res_val && o_res_rdy.
  - OUTPUT -> IDLE: on o_pnt_val && i_pnt_rdy.
- IDLE:
  - RAM write takes effect on the same edge as i_wr_val.
  - i_start in the same cycle as a write: the write happens first; the stream sees the new data.
- STREAM:
  - RAM read has 1-cycle latency. First o_ps_val is asserted 2 cycles after i_start.
  - Output is registered, and a 1-entry skid buffer sustains 1 beat/clk under continuous i_ps_rdy.
  - o_ps_val/dat/ctl/sop/eop are held stable while i_ps_rdy=0 (AXI-stream rule).
  - Index increments per accepted beat and wraps NUM_IN-1 -> 0.
  - pass_cnt increments on each accepted eop beat.
  - Normal mode: ends when pass_cnt reaches KEY_BITS, i.e. exactly NUM_IN*KEY_BITS beats.
  - Single-add mode: exactly one beat, index 0, ctl[0]=1, sop=eop=1.
  - No extra beats are issued after the final one; o_ps_val drops the cycle after the final handshake.
- o_res_rdy:
  - High in WAIT_RES.
  - Also high in STREAM, to catch an early result.
  - An early result (i_res_val in STREAM):
    - sets o_err;
    - is captured;
    - stops the stream at once, including any pending skid beat;
    - moves the state to OUTPUT.
- OUTPUT:
  - o_pnt_val=1, with o_pnt_dat holding the captured result until accepted.
  - o_res_rdy=0 in OUTPUT and IDLE.
  - i_res_val seen in IDLE sets o_err and the data is dropped.
- i_start while o_busy=1: ignored, and sets o_err.
- i_wr_val while o_wr_rdy=0: ignored, RAM unchanged. o_err is not set.
- o_err:
  - Held until the next accepted i_start or reset.
  - Clearing on start has priority over a same-cycle set from other events.
- Width rules:
  - pass_cnt saturates at KEY_BITS.
  - The index counter is $clog2(NUM_IN) bits. For non-power-of-2 NUM_IN it wraps by compare, not overflow.

Test Plan:
- Load NUM_IN=4 pairs (scalar = 1,2,3,4), KEY_BITS=3, mode 0, i_ps_rdy=1 -> 12 beats in index order 0,1,2,3 x3; sop on beats 1,5,9; eop on beats 4,8,12; o_pass_cnt=3; o_ps_val low after beat 12.
- Repeat with i_ps_rdy toggling 1-0 each cycle -> same 12 beats, no drops or duplicates, data stable while rdy=0.
- Mode 1 start -> one beat of pair 0 with ctl=8'h01, sop=eop=1; then i_res_val with 768'hABC -> o_pnt_dat=768'hABC; o_err=0.
- Inject i_res_val after 5 of 12 beats -> o_err=1, stream stops, result output; the next i_start clears o_err.
- Assert i_start and i_wr_val during STREAM -> both ignored; RAM unchanged (read back on next run); o_err=1.
- Pull i_rst_n low mid-STREAM at beat 6 -> next cycle o_ps_val=0, o_busy=0, o_wr_rdy=1; a new run streams the original RAM data.
